tx_fifo_ctrl: RTL and testbench

//  Transmit-side buffer and sequencer, mirroring the receive FIFO on the Rx path.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/tx_fifo_mem.sv | 88 ++++++++
 rtl/tx_fifo_ctrl.sv | 99 +++++++++
 tb/tb_tx_fifo_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and sizing helpers for the UART transmit feed path
package uart_pkg;

  // Sequencer states for feeding bytes into TX_FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } tx_feed_state_e;

  // Pointer width for a power-of-two FIFO; never narrower than one bit
  function automatic int FIFO_PTR_W(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// rtl/tx_fifo_mem.sv - transmit byte storage with pointers, occupancy and sticky overflow
module tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_wr_en,
  input  logic [DATA_BITS-1:0]               i_wr_data,
  input  logic                               i_pop,
  input  logic                               i_flush,
  output logic [DATA_BITS-1:0]               o_head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_empty,
  output logic                               o_full,
  output logic                               o_overflow
);

  localparam int PW = FIFO_PTR_W(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_wr_ok;
  logic w_do_wr;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // Flush outranks both sides: nothing moves on a flush edge
  assign w_do_pop = i_pop && !w_empty && !i_flush;
  // A full FIFO still takes a byte when the head leaves on the same edge
  assign w_wr_ok  = !w_full || w_do_pop;
  assign w_do_wr  = i_wr_en && !i_flush && w_wr_ok;

  // Storage array; contents are don't-care until pointed at, so no reset
  always_ff @(posedge i_clk) begin
    if (i_rst && w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_wr && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_wr) begin
        r_count <= r_count - 1'b1;
      end
      if (i_wr_en && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/tx_fifo_ctrl.sv
// rtl/tx_fifo_ctrl.sv - transmit FIFO and start/busy sequencer in front of TX_FSM
module tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               Tx_Write,
  input  logic [DATA_BITS-1:0]               Tx_Wr_Data,
  input  logic                               Tx_Flush,
  input  logic                               Tx_Busy,
  output logic [DATA_BITS-1:0]               Tx_Data_Out,
  output logic                               Transmit_Start_Out,
  output logic                               Tx_FIFO_Empty,
  output logic                               Tx_FIFO_Full,
  output logic                               Tx_FIFO_Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    Tx_Count,
  output logic                               Tx_Idle
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_feed_state_e       r_state;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_start;

  logic [DATA_BITS-1:0] w_head;
  logic [CW-1:0]        w_count;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_overflow;
  logic                 w_pop;

  // Only pop when the transmitter is free and no flush is wiping the queue
  assign w_pop = (r_state == IDLE) && !w_empty && !Tx_Busy && !Tx_Flush;

  tx_fifo_mem #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_wr_en    (Tx_Write),
    .i_wr_data  (Tx_Wr_Data),
    .i_pop      (w_pop),
    .i_flush    (Tx_Flush),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_overflow (w_overflow)
  );

  // Feed sequencer: latch head on pop, raise start until TX_FSM reports busy,
  // then wait for busy to drop before the next pop
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_start <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data  <= w_head;
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (Tx_Busy) begin
            r_start <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!Tx_Busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_start <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Tx_Data_Out        = r_data;
  assign Transmit_Start_Out = r_start;
  assign Tx_FIFO_Empty      = w_empty;
  assign Tx_FIFO_Full       = w_full;
  assign Tx_FIFO_Overflow   = w_overflow;
  assign Tx_Count           = w_count;
  assign Tx_Idle            = w_empty && (r_state == IDLE) && !Tx_Busy;

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// tb/tb_tx_fifo_ctrl.sv - self-checking bench for tx_fifo_ctrl against a queue-based model
module tb_tx_fifo_ctrl;

  localparam int DEPTH = 8;

  logic       clk;
  logic       Rst;
  logic       Tx_Write;
  logic [7:0] Tx_Wr_Data;
  logic       Tx_Flush;
  logic       Tx_Busy;
  logic [7:0] Tx_Data_Out;
  logic       Transmit_Start_Out;
  logic       Tx_FIFO_Empty;
  logic       Tx_FIFO_Full;
  logic       Tx_FIFO_Overflow;
  logic [3:0] Tx_Count;
  logic       Tx_Idle;

  tx_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .Clk                (clk),
    .Rst                (Rst),
    .Tx_Write           (Tx_Write),
    .Tx_Wr_Data         (Tx_Wr_Data),
    .Tx_Flush           (Tx_Flush),
    .Tx_Busy            (Tx_Busy),
    .Tx_Data_Out        (Tx_Data_Out),
    .Transmit_Start_Out (Transmit_Start_Out),
    .Tx_FIFO_Empty      (Tx_FIFO_Empty),
    .Tx_FIFO_Full       (Tx_FIFO_Full),
    .Tx_FIFO_Overflow   (Tx_FIFO_Overflow),
    .Tx_Count           (Tx_Count),
    .Tx_Idle            (Tx_Idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: queue contents, transmitter engagement, sticky overflow
  logic [7:0] m_q[$];
  logic [7:0] exp_sent[$];
  logic [7:0] sent_q[$];
  bit         m_eng;
  bit         m_seen;
  bit         m_ovf;
  logic [7:0] m_data;

  // Inputs applied for the edge the model is about to account for
  logic       p_wr, p_flush, p_rst, p_busy;
  logic [7:0] p_data;

  // Behavioural TX_FSM controls
  bit hold_busy = 0;
  int dly_min = 0, dly_max = 0, len_min = 10, len_max = 10;

  logic [16:0] dut_vec;
  assign dut_vec = {Tx_Count, Tx_FIFO_Full, Tx_FIFO_Empty, Tx_FIFO_Overflow,
                    Transmit_Start_Out, Tx_Data_Out, Tx_Idle};

  function automatic logic [16:0] model_vec();
    logic [3:0] c;
    c = 4'(m_q.size());
    return {c, m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_eng && !m_seen,
            m_data, (m_q.size() == 0) && !m_eng && !Tx_Busy};
  endfunction

  function automatic bit seq_match();
    if (sent_q.size() != exp_sent.size()) return 0;
    foreach (sent_q[i]) if (sent_q[i] !== exp_sent[i]) return 0;
    return 1;
  endfunction

  // Advance the model by one clock edge using the inputs that edge sampled
  task automatic model_update();
    bit pop;
    if (!p_rst) begin
      if (m_eng && !m_seen && exp_sent.size() > 0) void'(exp_sent.pop_back());
      m_q.delete();
      m_ovf = 0; m_eng = 0; m_seen = 0; m_data = 8'h00;
    end else begin
      pop = !m_eng && (m_q.size() != 0) && !p_busy && !p_flush;
      if (p_flush) begin
        m_q.delete();
        m_ovf = 0;
      end
      if (pop) begin
        m_data = m_q.pop_front();
        exp_sent.push_back(m_data);
        m_eng = 1; m_seen = 0;
      end else if (m_eng && !m_seen && p_busy) begin
        m_seen = 1;
      end else if (m_eng && m_seen && !p_busy) begin
        m_eng = 0;
      end
      if (p_wr && !p_flush) begin
        if (m_q.size() < DEPTH) m_q.push_back(p_data);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic drive_cycle(input logic wr, input logic [7:0] d, input logic fl);
    Tx_Write = wr; Tx_Wr_Data = d; Tx_Flush = fl;
    p_wr = wr; p_data = d; p_flush = fl; p_rst = Rst; p_busy = Tx_Busy;
    @(posedge clk); #2;
    model_update();
    Tx_Write = 1'b0; Tx_Flush = 1'b0;
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (m_q.size() == 0 && !m_eng && !Tx_Busy) begin ok = 1; break; end
      drive_cycle(1'b0, 8'h00, 1'b0);
    end
    if (m_q.size() == 0 && !m_eng && !Tx_Busy) ok = 1;
  endtask

  // Behavioural TX_FSM: answers start with busy after a delay, holds busy a while
  int tx_phase = 0, tx_wait = 0, tx_left = 0;
  bit tx_prev_start = 0;
  initial begin
    Tx_Busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!Rst) begin
        tx_phase = 0; Tx_Busy = 1'b0;
      end else if (hold_busy) begin
        Tx_Busy = 1'b1; tx_phase = 0;
        if (Transmit_Start_Out && !tx_prev_start) sent_q.push_back(Tx_Data_Out);
      end else begin
        case (tx_phase)
          0: begin
            Tx_Busy = 1'b0;
            if (Transmit_Start_Out) begin
              tx_wait = $urandom_range(dly_max, dly_min);
              tx_phase = 1;
            end
          end
          1: begin
            if (tx_wait == 0) begin
              Tx_Busy = 1'b1;
              sent_q.push_back(Tx_Data_Out);
              tx_left = $urandom_range(len_max, len_min);
              tx_phase = 2;
            end else begin
              tx_wait--;
            end
          end
          default: begin
            tx_left--;
            if (tx_left <= 0) begin Tx_Busy = 1'b0; tx_phase = 0; end
          end
        endcase
      end
      tx_prev_start = Transmit_Start_Out;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
    $fatal(1);
  end

  task automatic test_reset();
    Rst = 1'b0;
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (dut_vec !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, {4'd0, 4'b0100, 8'h00, 1'b1});
    end
    Rst = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (Tx_Idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", Tx_Idle); end
  endtask

  task automatic test_basic();
    bit ok;
    sent_q.delete(); exp_sent.delete();
    dly_min = 0; dly_max = 0; len_min = 10; len_max = 10;
    drive_cycle(1'b1, 8'h41, 1'b0);
    n_checks++;
    if (Tx_Count !== 4'd1 || Transmit_Start_Out !== 1'b0) begin
      n_fail++; $display("FAIL basic_first_write got=%0d/%b exp=1/0", Tx_Count, Transmit_Start_Out);
    end
    drive_cycle(1'b1, 8'h42, 1'b0);
    n_checks++;
    if (Transmit_Start_Out !== 1'b1 || Tx_Data_Out !== 8'h41 || Tx_Count !== 4'd1) begin
      n_fail++; $display("FAIL basic_first_pop got=%b/%h/%0d exp=1/41/1",
                         Transmit_Start_Out, Tx_Data_Out, Tx_Count);
    end
    drive_cycle(1'b1, 8'h43, 1'b0);
    for (int i = 0; i < 200; i++) begin
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL basic_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (m_q.size() == 0 && !m_eng && !Tx_Busy) break;
      drive_cycle(1'b0, 8'h00, 1'b0);
    end
    drain(50, ok);
    n_checks++;
    if (!ok || Tx_Count !== 4'd0 || Tx_Idle !== 1'b1) begin
      n_fail++; $display("FAIL basic_end got=%0d/%b exp=0/1", Tx_Count, Tx_Idle);
    end
    n_checks++;
    if (sent_q.size() != 3 || sent_q[0] !== 8'h41 || sent_q[1] !== 8'h42 || sent_q[2] !== 8'h43) begin
      n_fail++; $display("FAIL basic_order got=%0d bytes exp=41,42,43", sent_q.size());
    end
  endtask

  task automatic test_overflow();
    hold_busy = 1;
    drive_cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, 8'(8'h10 + i), 1'b0);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL ovf_write%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (Tx_FIFO_Full !== 1'b1 || Tx_Count !== 4'd8 || Tx_FIFO_Overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_state got=%b/%0d/%b exp=1/8/1",
                         Tx_FIFO_Full, Tx_Count, Tx_FIFO_Overflow);
    end
  endtask

  task automatic test_full_pop_write();
    bit ok;
    drive_cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (Tx_FIFO_Overflow !== 1'b0 || Tx_Count !== 4'd0 || Tx_FIFO_Empty !== 1'b1) begin
      n_fail++; $display("FAIL fpw_flush got=%b/%0d exp=0/0", Tx_FIFO_Overflow, Tx_Count);
    end
    sent_q.delete(); exp_sent.delete();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'($urandom_range(255, 0)), 1'b0);
    n_checks++;
    if (Tx_FIFO_Full !== 1'b1 || Tx_FIFO_Overflow !== 1'b0) begin
      n_fail++; $display("FAIL fpw_refill got=%b/%b exp=1/0", Tx_FIFO_Full, Tx_FIFO_Overflow);
    end
    dly_min = 0; dly_max = 2; len_min = 2; len_max = 4;
    hold_busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (!m_eng && m_q.size() > 0 && !Tx_Busy) break;
      drive_cycle(1'b0, 8'h00, 1'b0);
    end
    drive_cycle(1'b1, 8'h55, 1'b0);
    n_checks++;
    if (Tx_Count !== 4'd8 || Tx_FIFO_Overflow !== 1'b0 || Transmit_Start_Out !== 1'b1) begin
      n_fail++; $display("FAIL fpw_same_edge got=%0d/%b/%b exp=8/0/1",
                         Tx_Count, Tx_FIFO_Overflow, Transmit_Start_Out);
    end
    drain(400, ok);
    n_checks++;
    if (!ok || !seq_match() || sent_q.size() != 9 || sent_q[sent_q.size()-1] !== 8'h55) begin
      n_fail++; $display("FAIL fpw_drain got=%0d bytes exp=9 ending 55", sent_q.size());
    end
  endtask

  task automatic test_flush();
    int starts;
    sent_q.delete(); exp_sent.delete();
    dly_min = 0; dly_max = 0; len_min = 10; len_max = 10;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (m_eng && m_seen) break;
      drive_cycle(1'b0, 8'h00, 1'b0);
    end
    n_checks++;
    if (Tx_Count !== 4'd5) begin n_fail++; $display("FAIL flush_pre got=%0d exp=5", Tx_Count); end
    drive_cycle(1'b1, 8'hEE, 1'b1);
    n_checks++;
    if (Tx_Count !== 4'd0 || Tx_FIFO_Empty !== 1'b1 || Tx_FIFO_Overflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_edge got=%0d/%b/%b exp=0/1/0",
                         Tx_Count, Tx_FIFO_Empty, Tx_FIFO_Overflow);
    end
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0);
      if (Transmit_Start_Out) starts++;
    end
    n_checks++;
    if (starts != 0 || Tx_Idle !== 1'b1 || Tx_Count !== 4'd0) begin
      n_fail++; $display("FAIL flush_after got=%0d/%b exp=0/1", starts, Tx_Idle);
    end
    n_checks++;
    if (sent_q.size() != 1 || sent_q[0] !== 8'h60) begin
      n_fail++; $display("FAIL flush_inflight got=%0d bytes exp=1", sent_q.size());
    end
  endtask

  task automatic test_reset_in_start();
    bit ok;
    sent_q.delete(); exp_sent.delete();
    dly_min = 3; dly_max = 3; len_min = 3; len_max = 3;
    drive_cycle(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (m_eng && !m_seen) break;
      drive_cycle(1'b0, 8'h00, 1'b0);
    end
    Rst = 1'b0;
    drive_cycle(1'b0, 8'h00, 1'b0);
    Rst = 1'b1;
    n_checks++;
    if (Transmit_Start_Out !== 1'b0 || Tx_FIFO_Empty !== 1'b1 || Tx_Count !== 4'd0 || Tx_Data_Out !== 8'h00) begin
      n_fail++; $display("FAIL rst_start got=%b/%b/%0d exp=0/1/0",
                         Transmit_Start_Out, Tx_FIFO_Empty, Tx_Count);
    end
    dly_min = 0; dly_max = 2;
    drive_cycle(1'b1, 8'hA5, 1'b0);
    drain(100, ok);
    n_checks++;
    if (!ok || sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin
      n_fail++; $display("FAIL rst_then_a5 got=%0d bytes exp=1 (A5)", sent_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic wr, fl;
    sent_q.delete(); exp_sent.delete();
    dly_min = 0; dly_max = 2; len_min = 1; len_max = 6;
    for (int i = 0; i < 600; i++) begin
      wr = ($urandom_range(3, 0) != 0);
      fl = ($urandom_range(39, 0) == 0);
      drive_cycle(wr, 8'($urandom_range(255, 0)), fl);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    drain(400, ok);
    n_checks++;
    if (!ok || !seq_match()) begin
      n_fail++; $display("FAIL random_sequence got=%0d bytes exp=%0d", sent_q.size(), exp_sent.size());
    end
  endtask

  initial begin
    Rst = 1'b0; Tx_Write = 1'b0; Tx_Wr_Data = 8'h00; Tx_Flush = 1'b0;
    m_eng = 0; m_seen = 0; m_ovf = 0; m_data = 8'h00;
    @(posedge clk); #2;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop_write();
    test_flush();
    test_reset_in_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
